clk_gate_cell: RTL and testbench

- Glitch-free clock gate (clock buffer with enable) for the accelerator buffers.
- Produces a gated copy of `clk` that toggles only while the enable is active. The enable is sampled while `clk` is low, so `clk_o` never carries a runt pulse.
- Buffer banks use it to stop clocking when there is no read/write activity (enable = we | rd_en).
- Also provides a test-mode bypass, optional enable synchronisation, and an active-cycle counter for power accounting.

---
 rtl/clk_gate_cell.sv | 84 ++++++++
 tb/tb_clk_gate_cell.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/clk_gate_cell.sv
`timescale 1ns/1ps
// clk_gate_cell
//   Glitch-free clock gate with test bypass, optional enable synchroniser and
//   an active-cycle counter for power accounting.
//
//   The enable is captured by a latch that is transparent only while clk is
//   low. It is then ANDed with clk, so every clk_o high pulse is a full-width
//   copy of clk's high phase.
//
// Ports
//   clk        in   reference clock
//   rst_n      in   asynchronous active-low reset
//   ce         in   clock enable request
//   test_en    in   scan/test bypass, forces the gate open (also during reset)
//   cnt_clr    in   synchronous clear of active_cnt (wins over increment)
//   clk_o      out  gated clock
//   ce_q       out  latched enable currently gating clk_o
//   active_cnt out  number of clk cycles on which clk_o pulsed (wraps)
module clk_gate_cell #(
  parameter int SYNC_STAGES = 0,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 test_en,
  input  logic                 cnt_clr,
  output logic                 clk_o,
  output logic                 ce_q,
  output logic [CNT_WIDTH-1:0] active_cnt
);

  if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
    $fatal(1, "clk_gate_cell: SYNC_STAGES must be 0..3");
  end
  if (CNT_WIDTH < 1 || CNT_WIDTH > 64) begin : g_bad_cnt
    $fatal(1, "clk_gate_cell: CNT_WIDTH must be 1..64");
  end

  logic ce_s;
  logic en_d;
  logic en_lat;

  // Optional enable delay line. With no stages, ce is assumed to already be
  // in the clk domain and feeds the latch directly.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign ce_s = ce;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else begin
        sync_q[0] <= ce;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end
    assign ce_s = sync_q[SYNC_STAGES-1];
  end

  // During reset only test_en may open the gate, so scan clocks still reach
  // the downstream flops.
  assign en_d = rst_n ? (test_en | ce_s) : test_en;

  // Gating latch. The reset clear acts immediately, even in the high phase.
  // A high phase that is running when reset asserts may therefore be cut
  // short. Reset release leaves en_lat at 0 until the next low phase, so
  // releasing reset cannot produce a glitch.
  always_latch begin
    if (!rst_n && !test_en) en_lat <= 1'b0;
    else if (!clk)          en_lat <= en_d;
  end

  assign clk_o = clk & en_lat;
  assign ce_q  = en_lat;

  // At the rising edge en_lat holds the value that gates this cycle. The
  // counter runs off the ungated clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       active_cnt <= '0;
    else if (cnt_clr) active_cnt <= '0;
    else if (en_lat)  active_cnt <= active_cnt + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_clk_gate_cell.sv
`timescale 1ns/1ps
// Scoreboard bench for clk_gate_cell.
//   dut_a: SYNC_STAGES=0, CNT_WIDTH=4 (gating, glitch, bypass, wrap, clear)
//   dut_b: SYNC_STAGES=2, CNT_WIDTH=32 (synchroniser latency)
// The stimulus drives inputs in the low phase and queues the expected
// per-cycle response. The monitor samples each DUT 1 ns after every rising
// edge and compares against the queue. Separate watchers check that every
// clk_o rise falls on a clk rising edge and that every pulse is 5 ns wide.
module tb_clk_gate_cell;

  typedef struct {
    logic        pa;
    logic        qa;
    logic [3:0]  na;
    logic        pb;
    logic [31:0] nb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, ce_a, ce_b, te_a, te_b, clr;
  logic        clk_a_o, ce_q_a, clk_b_o, ce_q_b;
  logic [3:0]  cnt_a;
  logic [31:0] cnt_b;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  clk_gate_cell #(.SYNC_STAGES(0), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .ce(ce_a), .test_en(te_a), .cnt_clr(clr),
    .clk_o(clk_a_o), .ce_q(ce_q_a), .active_cnt(cnt_a));

  clk_gate_cell #(.SYNC_STAGES(2), .CNT_WIDTH(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .ce(ce_b), .test_en(te_b), .cnt_clr(clr),
    .clk_o(clk_b_o), .ce_q(ce_q_b), .active_cnt(cnt_b));

  function automatic longint to_ps(realtime t);
    return longint'(t * 1000.0);
  endfunction

  task automatic chk(string name, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Pulse-shape watchers. Rising edges of clk occur at 5 ns + k*10 ns.
  realtime rise_a, rise_b;
  bit      have_a = 0, have_b = 0;
  always @(posedge clk_a_o) begin
    rise_a = $realtime; have_a = 1;
    chk("clk_a_o_rise_phase", to_ps(rise_a) % 10000, 5000);
  end
  always @(negedge clk_a_o) if (have_a) begin
    have_a = 0;
    chk("clk_a_o_width_ps", to_ps($realtime) - to_ps(rise_a), 5000);
  end
  always @(posedge clk_b_o) begin
    rise_b = $realtime; have_b = 1;
    chk("clk_b_o_rise_phase", to_ps(rise_b) % 10000, 5000);
  end
  always @(negedge clk_b_o) if (have_b) begin
    have_b = 0;
    chk("clk_b_o_width_ps", to_ps($realtime) - to_ps(rise_b), 5000);
  end

  // Monitor: one expected record per cycle, sampled during the high phase.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pulse_a", clk_a_o, e.pa);
        chk("ce_q_a",  ce_q_a,  e.qa);
        chk("cnt_a",   cnt_a,   e.na);
        chk("pulse_b", clk_b_o, e.pb);
        chk("ce_q_b",  ce_q_b,  e.pb);
        chk("cnt_b",   cnt_b,   e.nb);
      end
    end
  end

  // One cycle of stimulus. Inputs are driven 1 ns into the low phase. With
  // glitch set, ce_a is also moved at 25 % and 75 % of the following high
  // phase, after the expected response for that edge has been queued.
  task automatic cyc(input logic ca, ta, ra, cl, cb,
                     input logic pa, qa, input logic [3:0] na,
                     input logic pb, input logic [31:0] nb,
                     input bit glitch = 0, input logic g1 = 0, g2 = 0);
    exp_t e;
    @(negedge clk); #1;
    ce_a = ca; te_a = ta; rst_n = ra; clr = cl; ce_b = cb;
    e.pa = pa; e.qa = qa; e.na = na; e.pb = pb; e.nb = nb;
    q.push_back(e);
    if (glitch) begin
      @(posedge clk);
      #1.25 ce_a = g1;
      #2.5  ce_a = g2;
    end
  endtask

  initial begin
    rst_n = 1'b0; ce_a = 1'b1; ce_b = 1'b0; te_a = 1'b0; te_b = 1'b0; clr = 1'b0;

    // Reset holds the gate shut even with ce=1.
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    // Release: pulses from the first rising edge, exactly 5 of them.
    for (int i = 1; i <= 5; i++) cyc(1, 0, 1, 0, 0, 1, 1, 4'(i), 0, 0);
    repeat (2) cyc(0, 0, 1, 0, 0, 0, 0, 4'd5, 0, 0);

    // ce moving inside the high phase must not disturb clk_o.
    cyc(0, 0, 1, 0, 0, 0, 0, 4'd5, 0, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 0, 1, 1, 4'd6, 0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 0, 4'd6, 0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 4'd6, 0, 0);

    // Test bypass: 2 cycles inside reset (counter held at 0), 4 outside.
    repeat (2) cyc(0, 1, 0, 0, 0, 1, 1, 4'd0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 1, 0, 0, 1, 1, 4'(i), 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 4'd4, 0, 0);

    // Counter: clear, then 18 active cycles on a 4-bit counter wrap to 2.
    cyc(0, 0, 1, 1, 0, 0, 0, 4'd0, 0, 0);
    for (int i = 1; i <= 18; i++) cyc(1, 0, 1, 0, 0, 1, 1, 4'(i % 16), 0, 0);
    // A clear on an active cycle wins over the increment.
    cyc(1, 0, 1, 1, 0, 1, 1, 4'd0, 0, 0);
    cyc(1, 0, 1, 0, 0, 1, 1, 4'd1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 4'd1, 0, 0);

    // Two-stage synchroniser: ce_b rises before edge N, pulses from N+2.
    // It falls before edge M=N+4, and the last pulse is at M+1.
    cyc(0, 0, 1, 0, 1, 0, 0, 4'd1, 0, 0);
    cyc(0, 0, 1, 0, 1, 0, 0, 4'd1, 0, 0);
    cyc(0, 0, 1, 0, 1, 0, 0, 4'd1, 1, 1);
    cyc(0, 0, 1, 0, 1, 0, 0, 4'd1, 1, 2);
    cyc(0, 0, 1, 0, 0, 0, 0, 4'd1, 1, 3);
    cyc(0, 0, 1, 0, 0, 0, 0, 4'd1, 1, 4);
    cyc(0, 0, 1, 0, 0, 0, 0, 4'd1, 0, 4);
    cyc(0, 0, 1, 0, 0, 0, 0, 4'd1, 0, 4);

    // Let the monitor drain the queue, within a bounded wait.
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d records left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
